// File: rtl/br_pkg.sv
// Shared definitions for the branch resolution unit: condition codes and
// the saturating-counter helpers used by the prediction table and statistics.
package br_pkg;

    localparam logic [3:0] BR_BEQ    = 4'd0;
    localparam logic [3:0] BR_BGEZ   = 4'd1;
    localparam logic [3:0] BR_BGTZ   = 4'd2;
    localparam logic [3:0] BR_BLEZ   = 4'd3;
    localparam logic [3:0] BR_BLTZ   = 4'd4;
    localparam logic [3:0] BR_BNE    = 4'd5;
    localparam logic [3:0] BR_BLT    = 4'd6;
    localparam logic [3:0] BR_BLTU   = 4'd7;
    localparam logic [3:0] BR_BGE    = 4'd8;
    localparam logic [3:0] BR_BGEU   = 4'd9;
    localparam logic [3:0] BR_ALWAYS = 4'd10;

    // Weakly not-taken starting value for a counter of width w.
    function automatic logic [31:0] ctr_init(input int unsigned w);
        return (32'd1 << (w - 32'd1)) - 32'd1;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? max_v : (v + 32'd1);
    endfunction

    function automatic logic [31:0] sat_dec(input logic [31:0] v);
        return (v == 32'd0) ? 32'd0 : (v - 32'd1);
    endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch condition evaluator: decodes br_type and compares the
// forwarded operands, flagging codes that are not branches at all.
module br_cond_eval
    import br_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] cmp_a,
    input  logic [DATA_W-1:0] cmp_b,
    input  logic [3:0]        br_type,
    output logic              is_branch,
    output logic              taken
);

    logic a_neg_s;
    logic a_zero_s;
    logic eq_s;
    logic lt_s;
    logic ltu_s;

    assign a_neg_s  = cmp_a[DATA_W-1];
    assign a_zero_s = (cmp_a == {DATA_W{1'b0}});
    assign eq_s     = (cmp_a == cmp_b);
    assign lt_s     = ($signed(cmp_a) < $signed(cmp_b));
    assign ltu_s    = (cmp_a < cmp_b);

    // Condition decode; unused codes fall through as non-branches.
    always_comb begin
        is_branch = 1'b1;
        taken     = 1'b0;
        case (br_type)
            BR_BEQ:    taken = eq_s;
            BR_BGEZ:   taken = ~a_neg_s;
            BR_BGTZ:   taken = ~a_neg_s & ~a_zero_s;
            BR_BLEZ:   taken = a_neg_s | a_zero_s;
            BR_BLTZ:   taken = a_neg_s;
            BR_BNE:    taken = ~eq_s;
            BR_BLT:    taken = lt_s;
            BR_BLTU:   taken = ltu_s;
            BR_BGE:    taken = ~lt_s;
            BR_BGEU:   taken = ~ltu_s;
            BR_ALWAYS: taken = 1'b1;
            default: begin
                is_branch = 1'b0;
                taken     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/br_resolve_unit.sv
// Branch resolution unit: resolves the ID-stage branch, registers the outcome
// for EX, trains a PC-indexed saturating-counter table and keeps statistics.
module br_resolve_unit
    import br_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int PC_W      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CTR_W     = 2,
    parameter int STAT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   lk_pc,
    output logic              lk_taken,
    input  logic              res_valid,
    input  logic [PC_W-1:0]   res_pc,
    input  logic              res_pred,
    input  logic [DATA_W-1:0] cmp_a,
    input  logic [DATA_W-1:0] cmp_b,
    input  logic [3:0]        br_type,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic              out_taken,
    output logic              out_mispred,
    output logic [STAT_W-1:0] br_cnt,
    output logic [STAT_W-1:0] miss_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_init(CTR_W));
    localparam logic [31:0]      CTR_MAX  = 32'({CTR_W{1'b1}});
    localparam logic [31:0]      STAT_MAX = 32'({STAT_W{1'b1}});

    logic [CTR_W-1:0]  tbl_q [BHT_DEPTH];
    logic [IDX_W-1:0]  lk_idx_s;
    logic [IDX_W-1:0]  res_idx_s;
    logic [CTR_W-1:0]  tbl_cur_s;
    logic              tbl_we_s;
    logic [CTR_W-1:0]  tbl_wdata_s;
    logic              is_branch_s;
    logic              taken_s;
    logic              accept_s;
    logic              mispred_s;
    logic              unused_pc_bits_s;

    logic              out_valid_q,   out_valid_d;
    logic              out_taken_q,   out_taken_d;
    logic              out_mispred_q, out_mispred_d;
    logic [STAT_W-1:0] br_cnt_q,      br_cnt_d;
    logic [STAT_W-1:0] miss_cnt_q,    miss_cnt_d;

    // Word-aligned PCs: bits [1:0] and everything above the index never select an entry.
    assign lk_idx_s  = lk_pc[IDX_W+1:2];
    assign res_idx_s = res_pc[IDX_W+1:2];
    assign tbl_cur_s = tbl_q[res_idx_s];
    assign unused_pc_bits_s = ^{lk_pc[PC_W-1:IDX_W+2], lk_pc[1:0],
                                res_pc[PC_W-1:IDX_W+2], res_pc[1:0]};

    br_cond_eval #(
        .DATA_W (DATA_W)
    ) u_cond (
        .cmp_a     (cmp_a),
        .cmp_b     (cmp_b),
        .br_type   (br_type),
        .is_branch (is_branch_s),
        .taken     (taken_s)
    );

    assign accept_s  = res_valid & ~stall & ~flush;
    assign mispred_s = is_branch_s & (taken_s ^ res_pred);

    // Next-state for the EX register, table write port and statistics; stall freezes everything.
    always_comb begin
        out_valid_d   = 1'b0;
        out_taken_d   = 1'b0;
        out_mispred_d = 1'b0;
        br_cnt_d      = br_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        tbl_we_s      = 1'b0;
        tbl_wdata_s   = tbl_cur_s;
        if (stall) begin
            out_valid_d   = out_valid_q;
            out_taken_d   = out_taken_q;
            out_mispred_d = out_mispred_q;
        end else if (accept_s) begin
            out_valid_d   = 1'b1;
            out_taken_d   = taken_s & is_branch_s;
            out_mispred_d = mispred_s;
            if (is_branch_s) begin
                tbl_we_s    = 1'b1;
                tbl_wdata_s = taken_s ? CTR_W'(sat_inc(32'(tbl_cur_s), CTR_MAX))
                                      : CTR_W'(sat_dec(32'(tbl_cur_s)));
                br_cnt_d    = STAT_W'(sat_inc(32'(br_cnt_q), STAT_MAX));
                if (mispred_s) begin
                    miss_cnt_d = STAT_W'(sat_inc(32'(miss_cnt_q), STAT_MAX));
                end else begin
                    miss_cnt_d = miss_cnt_q;
                end
            end else begin
                br_cnt_d   = br_cnt_q;
                miss_cnt_d = miss_cnt_q;
            end
        end else begin
            out_valid_d   = 1'b0;
            out_taken_d   = 1'b0;
            out_mispred_d = 1'b0;
        end
    end

    // EX-stage result register and statistics counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q   <= 1'b0;
            out_taken_q   <= 1'b0;
            out_mispred_q <= 1'b0;
            br_cnt_q      <= {STAT_W{1'b0}};
            miss_cnt_q    <= {STAT_W{1'b0}};
        end else begin
            out_valid_q   <= out_valid_d;
            out_taken_q   <= out_taken_d;
            out_mispred_q <= out_mispred_d;
            br_cnt_q      <= br_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
        end
    end

    // Prediction table: single write port, all entries return to weakly not-taken on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                tbl_q[i] <= CTR_INIT;
            end
        end else if (tbl_we_s) begin
            tbl_q[res_idx_s] <= tbl_wdata_s;
        end
    end

    // No bypass: a lookup colliding with this cycle's update sees the old counter.
    assign lk_taken    = tbl_q[lk_idx_s][CTR_W-1];
    assign out_valid   = out_valid_q;
    assign out_taken   = out_taken_q;
    assign out_mispred = out_mispred_q;
    assign br_cnt      = br_cnt_q;
    assign miss_cnt    = miss_cnt_q;

endmodule
